// File: rtl/bus_mem_responder.sv
// Bus target that services word-bus transactions from an on-chip RAM with a
// fixed, programmable response latency. One transaction outstanding at a time.
module bus_mem_responder #(
  parameter int          DEPTH_LOG2  = 12,
  parameter logic [29:0] BASE        = 30'd0,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] bus_addr,
  input  logic        bus_start,
  input  logic        bus_write,
  input  logic [31:0] bus_data_wr,
  input  logic [3:0]  bus_data_be,
  output logic        bus_ready,
  output logic [31:0] bus_data_rd
);

  localparam int          DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [29:0]             req_addr;
  logic                    req_write;
  logic [31:0]             req_data;
  logic [3:0]              req_be;
  logic                    rd_en;
  logic [31:0]             rd_word;
  logic [31:0]             mem [DEPTH];

  logic                    access;
  logic                    hit;
  logic [DEPTH_LOG2-1:0]   idx;

  assign access = (state == S_WAIT) && (cnt == 4'd0);
  assign hit    = (req_addr[29:DEPTH_LOG2] == BASE[29:DEPTH_LOG2]);
  assign idx    = req_addr[DEPTH_LOG2-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      req_addr  <= '0;
      req_write <= 1'b0;
      req_data  <= '0;
      req_be    <= '0;
      rd_en     <= 1'b0;
      bus_ready <= 1'b0;
    end else begin
      bus_ready <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          // A start seen in the response cycle is accepted, giving back-to-back service.
          if (bus_start) begin
            req_addr  <= bus_addr;
            req_write <= bus_write;
            req_data  <= bus_data_wr;
            req_be    <= bus_data_be;
            cnt       <= WS;
            state     <= S_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= S_RESP;
            bus_ready <= 1'b1;
            rd_en     <= !req_write && hit;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Block RAM: byte-masked write and registered read share the access edge.
  always_ff @(posedge clk) begin
    if (access) begin
      if (req_write && hit) begin
        for (int i = 0; i < 4; i++) begin
          if (req_be[i]) mem[idx][i*8 +: 8] <= req_data[i*8 +: 8];
        end
      end
      rd_word <= mem[idx];
    end
  end

  assign bus_data_rd = (bus_ready && rd_en) ? rd_word : 32'h0;

endmodule
